// File: rtl/calc_pkg.sv
// Shared definitions for the multi-cycle calculator: opcodes, sequencer
// states and small opcode-decode helpers used by the sequencer.
package calc_pkg;

  // Calculator opcodes; the 8-bit ALU uses the same encoding for AND/OR/ADD/SUB
  localparam logic [2:0] OP_AND = 3'b001;
  localparam logic [2:0] OP_OR  = 3'b010;
  localparam logic [2:0] OP_ADD = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;
  localparam logic [2:0] OP_CMP = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } seq_state_t;

  // True for the five opcodes the calculator understands
  function automatic logic op_legal(input logic [2:0] op);
    return (op == OP_AND) || (op == OP_OR) || (op == OP_ADD) ||
           (op == OP_SUB) || (op == OP_CMP);
  endfunction

  // ALU opcode for a calculator opcode; compare is a subtraction on the ALU
  function automatic logic [2:0] alu_code(input logic [2:0] op);
    return (op == OP_CMP) ? OP_SUB : op;
  endfunction

  // Operations whose slices chain a carry/borrow into the next slice
  function automatic logic uses_carry(input logic [2:0] op);
    return (op == OP_ADD) || (op == OP_SUB) || (op == OP_CMP);
  endfunction

endpackage

// File: rtl/alu16_seq.sv
// Multi-cycle sequencer that runs one DW-bit operation over an external AW-bit
// combinational ALU, one slice per clock, least significant slice first, with
// the carry/borrow of each slice registered and fed into the next one.
module alu16_seq
  import calc_pkg::*;
#(
  parameter int DW = 16,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [2:0]    op,
  input  logic [DW-1:0] opa,
  input  logic [DW-1:0] opb,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          carry,
  output logic          err,
  output logic [AW-1:0] alu_a,
  output logic [AW-1:0] alu_b,
  output logic [2:0]    alu_cs,
  output logic          alu_cin,
  input  logic [AW-1:0] alu_result,
  input  logic          alu_carry,
  input  logic          alu_zero
);

  // DW must be a whole number of ALU slices
  localparam int N  = DW / AW;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  seq_state_t    state;
  logic [CW-1:0] cnt;
  logic [DW-1:0] a_reg;
  logic [DW-1:0] b_reg;
  logic [2:0]    op_reg;
  logic          chain;
  logic [DW-1:0] acc;

  logic [DW-1:0] acc_next;
  logic [DW-1:0] fin_result;
  logic          fin_zero;
  logic          fin_carry;
  logic          cmp_gt;

  // The ALU's own zero flag only covers one slice; zero is derived over DW
  logic unused_alu_zero;
  assign unused_alu_zero = alu_zero;

  // Partial result with the current slice's ALU output merged in
  always_comb begin
    acc_next = acc;
    acc_next[int'(cnt)*AW +: AW] = alu_result;
  end

  // Final result and flags as they will look once the last slice lands
  always_comb begin
    fin_result = '0;
    fin_zero   = 1'b0;
    fin_carry  = 1'b0;
    cmp_gt     = (alu_carry == 1'b0) && (acc_next != '0);
    case (op_reg)
      OP_ADD, OP_SUB: begin
        fin_result = acc_next;
        fin_zero   = (acc_next == '0);
        fin_carry  = alu_carry;
      end
      OP_CMP: begin
        fin_result = {{(DW-1){1'b0}}, cmp_gt};
      end
      OP_AND, OP_OR: begin
        fin_result = acc_next;
      end
      default: begin
        fin_result = '0;
      end
    endcase
  end

  // ALU drive: slice operands in RUN, a harmless decoded AND of zeros otherwise
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_cs  = OP_AND;
    alu_cin = 1'b0;
    if (state == S_RUN) begin
      alu_a   = a_reg[int'(cnt)*AW +: AW];
      alu_b   = b_reg[int'(cnt)*AW +: AW];
      alu_cs  = alu_code(op_reg);
      alu_cin = (cnt != '0) && uses_carry(op_reg) && chain;
    end
  end

  // Sequencer FSM with registered handshake, result and flag outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      op_reg <= OP_AND;
      chain  <= 1'b0;
      acc    <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      result <= '0;
      zero   <= 1'b0;
      carry  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_reg  <= opa;
            b_reg  <= opb;
            op_reg <= op;
            cnt    <= '0;
            chain  <= 1'b0;
            acc    <= '0;
            busy   <= 1'b1;
            if (op_legal(op)) begin
              state <= S_RUN;
            end else begin
              state  <= S_DONE;
              done   <= 1'b1;
              err    <= 1'b1;
              result <= '0;
              zero   <= 1'b0;
              carry  <= 1'b0;
            end
          end
        end
        S_RUN: begin
          acc   <= acc_next;
          chain <= alu_carry;
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            state  <= S_DONE;
            done   <= 1'b1;
            err    <= 1'b0;
            result <= fin_result;
            zero   <= fin_zero;
            carry  <= fin_carry;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu16_seq.sv
// Bench for alu16_seq with a behavioural 8-bit ALU attached to its back end.
// Expected results come from full-width arithmetic in the bench and travel
// through a scoreboard queue from stimulus to the done pulse.
module tb_alu16_seq;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [2:0]  op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic        busy;
  logic        done;
  logic [15:0] result;
  logic        zero;
  logic        carry;
  logic        err;
  logic [7:0]  alu_a;
  logic [7:0]  alu_b;
  logic [2:0]  alu_cs;
  logic        alu_cin;
  logic [7:0]  alu_result;
  logic        alu_carry;
  logic        alu_zero;

  typedef struct {
    string       tag;
    logic [15:0] res;
    logic        zero;
    logic        carry;
    logic        err;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  int          checks;
  int          failures;
  int unsigned cyc;
  int unsigned start_cyc;

  alu16_seq #(.DW(16), .AW(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .op         (op),
    .opa        (opa),
    .opb        (opb),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .zero       (zero),
    .carry      (carry),
    .err        (err),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_cs     (alu_cs),
    .alu_cin    (alu_cin),
    .alu_result (alu_result),
    .alu_carry  (alu_carry),
    .alu_zero   (alu_zero)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running edge counter used to measure latency
  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural 8-bit ALU: 001 AND, 010 OR, 011 ADD, 100 SUB (carry = borrow)
  always_comb begin
    logic [8:0] t;
    t          = 9'd0;
    alu_result = 8'h00;
    alu_carry  = 1'b0;
    case (alu_cs)
      3'b001: alu_result = alu_a & alu_b;
      3'b010: alu_result = alu_a | alu_b;
      3'b011: begin
        t          = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
        alu_result = t[7:0];
        alu_carry  = t[8];
      end
      3'b100: begin
        t          = {1'b0, alu_a} - {1'b0, alu_b} - {8'd0, alu_cin};
        alu_result = t[7:0];
        alu_carry  = t[8];
      end
      default: begin
        alu_result = 8'h00;
        alu_carry  = 1'b0;
      end
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent full-width model of the calculator
  function automatic exp_t model(input string tag, input logic [2:0] o,
                                 input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    logic [16:0] w;
    e.tag = tag; e.res = 16'h0; e.zero = 1'b0; e.carry = 1'b0; e.err = 1'b0; e.lat = 3;
    case (o)
      3'b001: e.res = a & b;
      3'b010: e.res = a | b;
      3'b011: begin
        w = {1'b0, a} + {1'b0, b};
        e.res = w[15:0]; e.carry = w[16]; e.zero = (w[15:0] == 16'h0);
      end
      3'b100: begin
        w = {1'b0, a} - {1'b0, b};
        e.res = w[15:0]; e.carry = w[16]; e.zero = (w[15:0] == 16'h0);
      end
      3'b101: e.res = (a > b) ? 16'h0001 : 16'h0000;
      default: begin
        e.err = 1'b1; e.lat = 1;
      end
    endcase
    return e;
  endfunction

  // Drive one request through the accepting edge and queue its expectation
  task automatic applyStimulus(input string tag, input logic [2:0] o,
                               input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    e = model(tag, o, a, b);
    @(negedge clk);
    op = o; opa = a; opb = b; start = 1'b1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    start_cyc = cyc;
    start = 1'b0;
    op = 3'b000; opa = 16'hDEAD; opb = 16'hBEEF;
    check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    if (e.err == 1'b0) begin
      check({tag, "_alu_cs"}, {29'd0, alu_cs}, (o == 3'b101) ? 32'd4 : {29'd0, o});
      check({tag, "_alu_a0"}, {24'd0, alu_a}, {24'd0, a[7:0]});
      check({tag, "_alu_cin0"}, {31'd0, alu_cin}, 32'd0);
    end
  endtask

  // Wait (bounded) for done, then compare against the oldest queued entry
  task automatic checkOutput();
    exp_t e;
    int lat;
    e = sb.pop_front();
    for (int i = 0; i < 20 && done !== 1'b1; i++) begin
      @(posedge clk);
      #1;
    end
    check({e.tag, "_done_seen"}, {31'd0, done}, 32'd1);
    if (done === 1'b1) begin
      lat = int'(cyc - start_cyc) + 1;
      check({e.tag, "_latency"}, lat, e.lat);
      check({e.tag, "_result"}, {16'd0, result}, {16'd0, e.res});
      check({e.tag, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
      check({e.tag, "_carry"}, {31'd0, carry}, {31'd0, e.carry});
      check({e.tag, "_err"}, {31'd0, err}, {31'd0, e.err});
      @(posedge clk);
      #1;
      check({e.tag, "_done_pulse"}, {31'd0, done}, 32'd0);
      check({e.tag, "_busy_clear"}, {31'd0, busy}, 32'd0);
      check({e.tag, "_result_held"}, {16'd0, result}, {16'd0, e.res});
    end
  endtask

  initial begin
    logic saw_done;
    checks = 0; failures = 0;
    rst_n = 1'b0; start = 1'b0; op = 3'b000; opa = 16'h0; opb = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", {16'd0, result}, 32'd0);
    check("rst_flags", {29'd0, zero, carry, err}, 32'd0);
    check("rst_alu_cs", {29'd0, alu_cs}, 32'd1);
    check("rst_alu_ab", {15'd0, alu_a, alu_b, alu_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("add_ff_1", 3'b011, 16'h00FF, 16'h0001);    checkOutput();
    applyStimulus("add_wrap", 3'b011, 16'hFFFF, 16'h0001);    checkOutput();
    applyStimulus("sub_100_1", 3'b100, 16'h0100, 16'h0001);   checkOutput();
    applyStimulus("sub_0_1", 3'b100, 16'h0000, 16'h0001);     checkOutput();
    applyStimulus("cmp_gt", 3'b101, 16'h0100, 16'h00FF);      checkOutput();
    applyStimulus("cmp_eq", 3'b101, 16'h1234, 16'h1234);      checkOutput();
    applyStimulus("cmp_lt", 3'b101, 16'h00FF, 16'h0100);      checkOutput();
    applyStimulus("and", 3'b001, 16'hF0F0, 16'h3C3C);         checkOutput();
    applyStimulus("or", 3'b010, 16'h0F00, 16'h00A5);          checkOutput();
    applyStimulus("sub_eq", 3'b100, 16'hA5A5, 16'hA5A5);      checkOutput();
    applyStimulus("ill_111", 3'b111, 16'h1234, 16'h5678);     checkOutput();
    applyStimulus("ill_000", 3'b000, 16'h1234, 16'h5678);     checkOutput();

    // A second start while busy must not disturb the running operation
    applyStimulus("busy_start", 3'b011, 16'h1111, 16'h2222);
    @(negedge clk);
    start = 1'b1; op = 3'b100; opa = 16'hFFFF; opb = 16'h0001;
    @(negedge clk);
    start = 1'b0;
    checkOutput();
    saw_done = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    check("busy_start_no_extra_done", {31'd0, saw_done}, 32'd0);

    // Reset in the middle of RUN aborts with no done pulse
    applyStimulus("abort", 3'b011, 16'h00FF, 16'h0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_result", {16'd0, result}, 32'd0);
    check("abort_flags", {28'd0, done, zero, carry, err}, 32'd0);
    check("abort_alu_cs", {29'd0, alu_cs}, 32'd1);
    void'(sb.pop_front());
    saw_done = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      saw_done = saw_done | done;
    end
    check("abort_no_done", {31'd0, saw_done}, 32'd0);

    applyStimulus("add_after_rst", 3'b011, 16'h7FFF, 16'h8001); checkOutput();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
